ysyx_22040237_mc_ctrl: RTL and testbench
========================================

Name: ysyx_22040237_mc_ctrl

Overview:
- Multi-cycle control FSM for the NPC core.
- Sequences one instruction at a time through fetch, decode, execute, optional data-memory access and writeback.
- Drives the instruction-register latch, PC update, regfile write strobe and both memory request handshakes.
- Consumes decode flags from the decode unit (invalid_inst, inst_ebreak, jump_flag, rd_w_en, load/store class); owns halt/error status and the cycle/instret counters.

Parameters:
TIMEOUT_CYCLES, 256, max cycles any memory handshake state may wait before error (>=2)
CNT_W, 64, width of cycle_cnt and instret_cnt

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
run_en  input  1  start/continue execution; sampled in S_IDLE and S_WB
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  fetch request accepted
imem_rsp_valid  input  1  fetch data valid (inst on IFU bus)
ir_we  output  1  latch fetched instruction into IR
invalid_inst  input  1  decode: unsupported opcode
inst_ebreak  input  1  decode: ebreak
jump_flag  input  1  decode: jal/jalr
rd_w_en  input  1  decode: instruction writes rd
is_load  input  1  decode: load class
is_store  input  1  decode: store class
dmem_req_valid  output  1  data request valid
dmem_we  output  1  data request is write
dmem_req_ready  input  1  data request accepted
dmem_rsp_valid  input  1  data response/ack valid
rf_we  output  1  regfile write strobe
pc_we  output  1  PC update strobe
pc_sel  output  1  0: pc+4, 1: jump target from EXU
halt  output  1  sticky, ebreak retired
err  output  1  sticky, error state
err_code  output  2  01 invalid inst, 10 ifetch timeout, 11 dmem timeout
state  output  4  current state, debug
cycle_cnt  output  CNT_W  running cycles
instret_cnt  output  CNT_W  retired instructions

Behaviour:
- rst synchronous active-high, all state registers update on posedge clk.
- Reset values: state=S_IDLE, counters=0, halt=0, err=0, err_code=00, timeout counter=0. All strobes/valids are Moore outputs of state and are therefore 0 in S_IDLE.
- States:
  - S_IDLE: run_en=1 -> S_IF_REQ, else stay.
  - S_IF_REQ: imem_req_valid=1; imem_req_ready=1 -> S_IF_WAIT.
  - S_IF_WAIT: imem_rsp_valid=1 -> ir_we=1 (same cycle, combinational), -> S_ID.
  - S_ID: decision priority is invalid_inst -> S_ERR (err_code=01); else inst_ebreak -> S_HALT (instret_cnt+1); else -> S_EX.
  - S_EX: one cycle, EXU result settles; is_load|is_store -> S_MEM_REQ, else -> S_WB.
  - S_MEM_REQ: dmem_req_valid=1, dmem_we=is_store; dmem_req_ready=1 -> S_MEM_WAIT.
  - S_MEM_WAIT: dmem_rsp_valid=1 -> S_WB.
  - S_WB: pc_we=1, pc_sel=jump_flag, rf_we=rd_w_en & ~is_store, instret_cnt+1; run_en=1 -> S_IF_REQ, else -> S_IDLE.
  - S_HALT: absorbing; halt=1.
  - S_ERR: absorbing; err=1.
- Decode flags are only sampled in S_ID/S_EX/S_MEM_*/S_WB. The IR holds them stable from ir_we until the next ir_we.
- Latency: non-memory instruction = 5 cycles with zero-wait memory (IF_REQ, IF_WAIT, ID, EX, WB). Load/store = 7 cycles.
- Valid, once raised in a *_REQ state, stays high until ready. No retraction.
- A response arriving in the same cycle as its request is not accepted. The FSM only looks at rsp in *_WAIT.
- Timeout:
  - Counter clears on every state change and increments while in IF_REQ/IF_WAIT/MEM_REQ/MEM_WAIT.
  - On the cycle it equals TIMEOUT_CYCLES-1 with the exiting handshake still low -> S_ERR, err_code=10 (IF_*) or 11 (MEM_*).
  - Handshake arriving on that same cycle wins; no error.
- cycle_cnt increments every cycle when state is not S_HALT/S_ERR, including S_IDLE. Counters wrap modulo 2^CNT_W.
- rst mid-instruction: no write strobes issued, in-flight memory response ignored, return to S_IDLE next cycle.
- Only rst leaves S_HALT/S_ERR.

Decomposition:
- Package ysyx_22040237_ctrl_pkg: state encodings (S_IDLE=0 .. S_ERR=9), err_code constants, pc_sel constants.
- Sub-module ysyx_22040237_wdog: the timeout counter, with inputs clr and en and output expire.

Test Plan:
- Zero-wait addi, run_en=1 -> ir_we at cycle 2 after leaving IDLE, rf_we=1/pc_we=1/pc_sel=0 at cycle 5, instret_cnt=1.
- jal with rd_w_en=1 -> in S_WB pc_sel=1, rf_we=1; sd (is_store) with dmem_req_ready delayed 3 cycles -> dmem_req_valid held 4 cycles, dmem_we=1, rf_we=0 in WB.
- invalid_inst=1 in S_ID -> state=S_ERR, err=1, err_code=01, no further imem_req_valid; rst pulse -> S_IDLE, err=0.
- imem_rsp_valid never asserted, TIMEOUT_CYCLES=8 -> S_ERR exactly 8 cycles after entering S_IF_WAIT, err_code=10; rsp on the 8th cycle -> no error.
- ebreak after 3 addi -> halt=1, instret_cnt=4, cycle_cnt frozen thereafter.
- run_en dropped mid-instruction -> instruction completes, FSM enters S_IDLE after WB; rst asserted in S_MEM_WAIT -> no rf_we/pc_we, counters=0.

Source files
------------

// File: rtl/ysyx_22040237_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_ctrl_pkg
// Shared definitions for the NPC multi-cycle control FSM:
//   - state_t      : FSM state encoding (also exported on the debug port)
//   - ERR_*        : err_code values latched on entry to S_ERR
//   - PC_SEL_*     : next-PC source select
//   - is_hs_state  : true for states that wait on a memory handshake
// ---------------------------------------------------------------------------
package ysyx_22040237_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_IF_REQ   = 4'd1,
        S_IF_WAIT  = 4'd2,
        S_ID       = 4'd3,
        S_EX       = 4'd4,
        S_MEM_REQ  = 4'd5,
        S_MEM_WAIT = 4'd6,
        S_WB       = 4'd7,
        S_HALT     = 4'd8,
        S_ERR      = 4'd9
    } state_t;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_INVALID     = 2'b01;
    localparam logic [1:0] ERR_IF_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_MEM_TIMEOUT = 2'b11;

    localparam logic PC_SEL_SEQ  = 1'b0;
    localparam logic PC_SEL_JUMP = 1'b1;

    // States in which the watchdog is allowed to run.
    function automatic logic is_hs_state(input state_t s);
        case (s)
            S_IF_REQ, S_IF_WAIT, S_MEM_REQ, S_MEM_WAIT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040237_wdog.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_wdog
// Handshake timeout counter. Counts cycles while en is high; clr (or rst)
// zeroes it. expire is asserted on the cycle the count reaches
// TIMEOUT_CYCLES-1, i.e. the last cycle a handshake may still complete.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero the count (state change)
//   en         : count this cycle (handshake state)
//   expire     : final allowed cycle of the current wait
// ---------------------------------------------------------------------------
module ysyx_22040237_wdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_cnt;

    // Wait-cycle counter; cannot pass LAST because the FSM leaves the state then.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= {TW{1'b0}};
        end else if (en) begin
            r_cnt <= r_cnt + TW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign expire = en && (r_cnt == LAST);

endmodule

// File: rtl/ysyx_22040237_mc_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_mc_ctrl
// Multi-cycle control FSM for the NPC core: fetch, decode, execute,
// optional data-memory access, writeback - one instruction at a time.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   run_en                          : start/continue (sampled in IDLE and WB)
//   imem_req_valid/ready, rsp_valid : instruction fetch handshake
//   ir_we                           : latch fetched instruction into IR
//   invalid_inst..is_store          : decode flags (stable from IR)
//   dmem_req_valid/we/ready, rsp    : data memory handshake
//   rf_we, pc_we, pc_sel            : writeback strobes
//   halt, err, err_code             : sticky status
//   state, cycle_cnt, instret_cnt   : debug state and performance counters
// ---------------------------------------------------------------------------
module ysyx_22040237_mc_ctrl #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    output logic             ir_we,
    input  logic             invalid_inst,
    input  logic             inst_ebreak,
    input  logic             jump_flag,
    input  logic             rd_w_en,
    input  logic             is_load,
    input  logic             is_store,
    output logic             dmem_req_valid,
    output logic             dmem_we,
    input  logic             dmem_req_ready,
    input  logic             dmem_rsp_valid,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             halt,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    import ysyx_22040237_ctrl_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_err_code;
    logic [1:0]       w_err_code_nxt;
    logic             w_instret_inc;
    logic             w_expire;
    logic             r_imem_req_valid;
    logic             r_dmem_req_valid;
    logic             r_pc_we;
    logic             r_halt;
    logic             r_err;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    ysyx_22040237_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_state_nxt != r_state),
        .en     (is_hs_state(r_state)),
        .expire (w_expire)
    );

    // Next-state, error-code and retire decision. A handshake on the expiring
    // cycle takes priority over the timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_err_code;
        w_instret_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run_en) w_state_nxt = S_IF_REQ;
                else        w_state_nxt = S_IDLE;
            end
            S_IF_REQ: begin
                if (imem_req_ready) begin
                    w_state_nxt = S_IF_WAIT;
                end else if (w_expire) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_IF_TIMEOUT;
                end else begin
                    w_state_nxt = S_IF_REQ;
                end
            end
            S_IF_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = S_ID;
                end else if (w_expire) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_IF_TIMEOUT;
                end else begin
                    w_state_nxt = S_IF_WAIT;
                end
            end
            S_ID: begin
                if (invalid_inst) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_INVALID;
                end else if (inst_ebreak) begin
                    w_state_nxt   = S_HALT;
                    w_instret_inc = 1'b1;
                end else begin
                    w_state_nxt = S_EX;
                end
            end
            S_EX: begin
                if (is_load || is_store) w_state_nxt = S_MEM_REQ;
                else                     w_state_nxt = S_WB;
            end
            S_MEM_REQ: begin
                if (dmem_req_ready) begin
                    w_state_nxt = S_MEM_WAIT;
                end else if (w_expire) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_MEM_TIMEOUT;
                end else begin
                    w_state_nxt = S_MEM_REQ;
                end
            end
            S_MEM_WAIT: begin
                if (dmem_rsp_valid) begin
                    w_state_nxt = S_WB;
                end else if (w_expire) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_MEM_TIMEOUT;
                end else begin
                    w_state_nxt = S_MEM_WAIT;
                end
            end
            S_WB: begin
                w_instret_inc = 1'b1;
                if (run_en) w_state_nxt = S_IF_REQ;
                else        w_state_nxt = S_IDLE;
            end
            S_HALT:  w_state_nxt = S_HALT;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, status and counters; Moore flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_err_code       <= ERR_NONE;
            r_imem_req_valid <= 1'b0;
            r_dmem_req_valid <= 1'b0;
            r_pc_we          <= 1'b0;
            r_halt           <= 1'b0;
            r_err            <= 1'b0;
            r_cycle_cnt      <= {CNT_W{1'b0}};
            r_instret_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_state          <= w_state_nxt;
            r_err_code       <= w_err_code_nxt;
            r_imem_req_valid <= (w_state_nxt == S_IF_REQ);
            r_dmem_req_valid <= (w_state_nxt == S_MEM_REQ);
            r_pc_we          <= (w_state_nxt == S_WB);
            r_halt           <= (w_state_nxt == S_HALT);
            r_err            <= (w_state_nxt == S_ERR);
            if ((r_state != S_HALT) && (r_state != S_ERR)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end else begin
                r_cycle_cnt <= r_cycle_cnt;
            end
            if (w_instret_inc) begin
                r_instret_cnt <= r_instret_cnt + CNT_W'(1);
            end else begin
                r_instret_cnt <= r_instret_cnt;
            end
        end
    end

    // Write strobes are masked during rst so an interrupted instruction
    // never commits architectural state.
    assign ir_we          = ~rst & (r_state == S_IF_WAIT) & imem_rsp_valid;
    assign rf_we          = ~rst & (r_state == S_WB) & rd_w_en & ~is_store;
    assign pc_we          = ~rst & r_pc_we;
    assign pc_sel         = ((r_state == S_WB) && jump_flag) ? PC_SEL_JUMP : PC_SEL_SEQ;
    assign imem_req_valid = r_imem_req_valid;
    assign dmem_req_valid = r_dmem_req_valid;
    assign dmem_we        = r_dmem_req_valid & is_store;
    assign halt           = r_halt;
    assign err            = r_err;
    assign err_code       = r_err_code;
    assign state          = r_state;
    assign cycle_cnt      = r_cycle_cnt;
    assign instret_cnt    = r_instret_cnt;

endmodule

// File: tb/tb_ysyx_22040237_mc_ctrl.sv
module tb_ysyx_22040237_mc_ctrl;

    localparam int TO = 8;
    localparam int CW = 64;

    logic          clk = 1'b0;
    logic          rst, run_en;
    logic          imem_req_valid, imem_req_ready, imem_rsp_valid, ir_we;
    logic          invalid_inst, inst_ebreak, jump_flag, rd_w_en, is_load, is_store;
    logic          dmem_req_valid, dmem_we, dmem_req_ready, dmem_rsp_valid;
    logic          rf_we, pc_we, pc_sel, halt, err;
    logic [1:0]    err_code;
    logic [3:0]    state;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    ysyx_22040237_mc_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run_en(run_en),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .ir_we(ir_we),
        .invalid_inst(invalid_inst), .inst_ebreak(inst_ebreak), .jump_flag(jump_flag),
        .rd_w_en(rd_w_en), .is_load(is_load), .is_store(is_store),
        .dmem_req_valid(dmem_req_valid), .dmem_we(dmem_we),
        .dmem_req_ready(dmem_req_ready), .dmem_rsp_valid(dmem_rsp_valid),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .halt(halt), .err(err),
        .err_code(err_code), .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: phase number (0 idle .. 9 error), cycles spent waiting
    // in the current handshake phase, and plain counters.
    int            m_phase = 0;
    int            m_waited = 0;
    logic [1:0]    m_code = 2'b00;
    logic [CW-1:0] m_cyc = '0;
    logic [CW-1:0] m_ret = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the instruction-sequencing rules, using inputs seen at the edge.
    task automatic model_step();
        int  nxt;
        bit  waiting, out_of_time;
        if (rst) begin
            m_phase = 0; m_waited = 0; m_code = 2'b00; m_cyc = '0; m_ret = '0;
        end else begin
            nxt = m_phase;
            waiting = (m_phase == 1) || (m_phase == 2) || (m_phase == 5) || (m_phase == 6);
            out_of_time = waiting && (m_waited == TO - 1);
            case (m_phase)
                0: if (run_en) nxt = 1;
                1: if (imem_req_ready) nxt = 2;
                   else if (out_of_time) begin nxt = 9; m_code = 2'b10; end
                2: if (imem_rsp_valid) nxt = 3;
                   else if (out_of_time) begin nxt = 9; m_code = 2'b10; end
                3: if (invalid_inst) begin nxt = 9; m_code = 2'b01; end
                   else if (inst_ebreak) begin nxt = 8; m_ret = m_ret + 1; end
                   else nxt = 4;
                4: nxt = (is_load || is_store) ? 5 : 7;
                5: if (dmem_req_ready) nxt = 6;
                   else if (out_of_time) begin nxt = 9; m_code = 2'b11; end
                6: if (dmem_rsp_valid) nxt = 7;
                   else if (out_of_time) begin nxt = 9; m_code = 2'b11; end
                7: begin m_ret = m_ret + 1; nxt = run_en ? 1 : 0; end
                default: nxt = m_phase;
            endcase
            if (m_phase < 8) m_cyc = m_cyc + 1;
            m_waited = (waiting && nxt == m_phase) ? m_waited + 1 : 0;
            m_phase = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_flags(input logic inv, input logic eb, input logic jp,
                             input logic rd, input logic ld, input logic st);
        invalid_inst = inv; inst_ebreak = eb; jump_flag = jp;
        rd_w_en = rd; is_load = ld; is_store = st;
    endtask

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("state",          64'(state),          64'(m_phase));
                check("imem_req_valid", 64'(imem_req_valid), 64'(m_phase == 1));
                check("ir_we",          64'(ir_we),          64'(!rst && m_phase == 2 && imem_rsp_valid));
                check("dmem_req_valid", 64'(dmem_req_valid), 64'(m_phase == 5));
                check("dmem_we",        64'(dmem_we),        64'(m_phase == 5 && is_store));
                check("rf_we",          64'(rf_we),          64'(!rst && m_phase == 7 && rd_w_en && !is_store));
                check("pc_we",          64'(pc_we),          64'(!rst && m_phase == 7));
                check("pc_sel",         64'(pc_sel),         64'(m_phase == 7 && jump_flag));
                check("halt",           64'(halt),           64'(m_phase == 8));
                check("err",            64'(err),            64'(m_phase == 9));
                check("err_code",       64'(err_code),       64'(m_code));
                check("cycle_cnt",      cycle_cnt,           m_cyc);
                check("instret_cnt",    instret_cnt,         m_ret);
            end
        end
    end

    initial begin
        int stuck;
        int p_if;
        int p_mem;
        int r;
        rst = 1'b1; run_en = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk_en = 1'b1;
        #1;
        check("rst state", 64'(state), 64'd0);
        check("rst cycle_cnt", cycle_cnt, 64'd0);
        check("rst instret", instret_cnt, 64'd0);
        check("rst halt/err/code", 64'({halt, err, err_code}), 64'd0);

        // Zero-wait addi
        rst = 1'b0; run_en = 1'b1;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1;
        set_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); #1 check("addi c1 state", 64'(state), 64'd1);
        tick(); #1 check("addi c2 ir_we", 64'(ir_we), 64'd1);
        tick(); tick(); tick();
        run_en = 1'b0;
        #1 check("addi c5 wb strobes", 64'({rf_we, pc_we, pc_sel}), 64'b110);
        tick(); #1 check("addi instret", instret_cnt, 64'd1);
        check("addi cycle_cnt", cycle_cnt, 64'd6);
        check("addi back idle", 64'(state), 64'd0);

        // jal then sd with delayed dmem_req_ready
        set_flags(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_en = 1'b1; dmem_req_ready = 1'b0;
        repeat (5) tick();
        #1 check("jal wb pc_sel/rf_we", 64'({pc_sel, rf_we}), 64'b11);
        tick();
        set_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) dmem_req_ready = 1'b1;
            #1 check("sd req held", 64'({dmem_req_valid, dmem_we}), 64'b11);
            tick();
        end
        dmem_req_ready = 1'b0;
        #1 check("sd req dropped", 64'({state, dmem_req_valid}), 64'({4'd6, 1'b0}));
        tick();
        run_en = 1'b0;
        #1 check("sd wb", 64'({rf_we, pc_we}), 64'b01);
        tick(); #1 check("sd instret", instret_cnt, 64'd3);

        // Invalid instruction
        set_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_req_ready = 1'b1; run_en = 1'b1;
        repeat (4) tick();
        #1 check("invalid err", 64'({state, err, err_code}), 64'({4'd9, 1'b1, 2'b01}));
        repeat (3) tick();
        #1 check("err no fetch", 64'(imem_req_valid), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0; run_en = 1'b0;
        #1 check("err cleared", 64'({state, err, err_code}), 64'd0);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fetch response timeout, then response on the last allowed cycle
        imem_rsp_valid = 1'b0; run_en = 1'b1;
        tick(); tick();
        repeat (7) tick();
        #1 check("if wait k7", 64'(state), 64'd2);
        tick(); #1 check("if timeout", 64'({state, err_code}), 64'({4'd9, 2'b10}));
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        repeat (7) tick();
        imem_rsp_valid = 1'b1;
        tick(); #1 check("rsp last cycle wins", 64'({state, err}), 64'({4'd3, 1'b0}));
        run_en = 1'b0;
        repeat (3) tick();

        // ebreak after three addi
        rst = 1'b1; tick(); rst = 1'b0; run_en = 1'b1;
        set_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (16) tick();
        inst_ebreak = 1'b1;
        repeat (3) tick();
        #1 check("ebreak halt", 64'({state, halt}), 64'({4'd8, 1'b1}));
        check("ebreak instret", instret_cnt, 64'd4);
        check("ebreak cycle_cnt", cycle_cnt, 64'd19);
        repeat (5) tick();
        #1 check("halt cycle frozen", cycle_cnt, 64'd19);

        // run_en dropped mid-instruction, then rst in MEM_WAIT
        rst = 1'b1; tick(); rst = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_en = 1'b1; tick(); run_en = 1'b0;
        repeat (4) tick();
        #1 check("drop run wb", 64'(pc_we), 64'd1);
        tick(); #1 check("drop run idle", 64'({state, 4'(instret_cnt)}), 64'({4'd0, 4'd1}));
        set_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_en = 1'b1; dmem_rsp_valid = 1'b0;
        repeat (6) tick();
        #1 check("load mem_wait", 64'(state), 64'd6);
        rst = 1'b1; dmem_rsp_valid = 1'b1;
        #1 check("rst no strobes", 64'({rf_we, pc_we}), 64'd0);
        tick();
        rst = 1'b0; run_en = 1'b0; dmem_rsp_valid = 1'b0;
        #1 check("rst mid idle", 64'(state), 64'd0);
        check("rst mid counters", cycle_cnt | instret_cnt, 64'd0);

        // Randomized traffic
        stuck = 0; p_if = 100; p_mem = 100;
        for (int c = 0; c < 4000; c++) begin
            if (m_phase >= 8) stuck++;
            else stuck = 0;
            rst = (stuck >= 4) || ($urandom_range(0, 399) == 0);
            run_en = ($urandom_range(0, 9) != 0);
            if (m_phase == 2) begin
                r = int'($urandom_range(0, 9));
                p_if  = (r < 5) ? 100 : (r < 8) ? 50 : (r < 9) ? 15 : 0;
                r = int'($urandom_range(0, 9));
                p_mem = (r < 5) ? 100 : (r < 8) ? 50 : (r < 9) ? 15 : 0;
                invalid_inst = ($urandom_range(0, 39) == 0);
                inst_ebreak  = ($urandom_range(0, 39) == 0);
                jump_flag    = ($urandom_range(0, 3) == 0);
                rd_w_en      = ($urandom_range(0, 9) < 7);
                r = int'($urandom_range(0, 9));
                is_load  = (r < 3);
                is_store = (r >= 3) && (r < 5);
            end
            imem_req_ready = (int'($urandom_range(0, 99)) < p_if);
            imem_rsp_valid = (int'($urandom_range(0, 99)) < p_if);
            dmem_req_ready = (int'($urandom_range(0, 99)) < p_mem);
            dmem_rsp_valid = (int'($urandom_range(0, 99)) < p_mem);
            tick();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
